// File: rtl/seq_pkg.sv
// Shared types and width helpers for the sequence_tx serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_GAP
  } seq_tx_state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_GAP   = 2;

  // Bits needed to hold values 0..max_val, never less than 1.
  function automatic int width_of(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // hit_count width for a given payload width.
  function automatic int hit_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/seq_run_counter.sv
// Tracks adjacency of 1 bits within a frame: keeps the previous emitted bit
// and counts bits that are 1 while the previous bit of the same frame was 1.
// Fed with the bit being registered onto data_out, so hit_count stays in step
// with the serial stream.
module seq_run_counter #(
  parameter int HIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [HIT_W-1:0] hit_count
);

  logic             prev_q, prev_d;
  logic [HIT_W-1:0] cnt_q, cnt_d;

  // Next previous-bit flag and hit count; clr marks the first bit of a frame.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (clr) begin
      prev_d = bit_en & bit_in;
      cnt_d  = '0;
    end else if (bit_en) begin
      if (bit_in && prev_q) cnt_d = cnt_q + HIT_W'(1);
      prev_d = bit_in;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hit_count = cnt_q;

endmodule

// File: rtl/sequence_tx.sv
// Serial pattern transmitter: accepts a word over valid/ready, shifts it out
// MSB-first one bit per clock, then holds data_out low for GAP cycles so a
// downstream ">=2 consecutive 1s" detector returns to idle.
// Optional feature macro: SEQ_TX_PARITY_EN appends an even-parity bit.
//
// Handshake: a word is accepted at a posedge where load_valid && load_ready;
// load_ready is high only in IDLE and outside reset. load_valid at any other
// time is ignored and nothing is queued.
module sequence_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  output logic                       data_out,
  output logic                       bit_valid,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic [hit_w(WIDTH)-1:0]    hit_count,
  output seq_tx_state_t              dbg_state
);

  localparam int CNT_W = width_of(WIDTH);
  localparam int GAP_W = width_of(GAP);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  seq_tx_state_t    state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             data_out_q, data_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             accept;
`ifdef SEQ_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign load_ready = (state_q == ST_IDLE) && !rst;
  assign accept     = load_valid && load_ready;

  // Next-state and next registered outputs; bit_cnt_q counts bits already on data_out.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    data_out_d    = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    parity_d      = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d       = ST_SHIFT;
          data_out_d    = load_data[WIDTH-1];
          bit_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          shreg_d       = load_data << 1;
          bit_cnt_d     = CNT_W'(1);
`ifdef SEQ_TX_PARITY_EN
          parity_d      = ^load_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q != LAST_BIT) begin
          data_out_d  = shreg_q[WIDTH-1];
          bit_valid_d = 1'b1;
          shreg_d     = shreg_q << 1;
          bit_cnt_d   = bit_cnt_q + CNT_W'(1);
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d     = ST_PARITY;
          data_out_d  = parity_q;
          bit_valid_d = 1'b1;
`else
          frame_done_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = (GAP == 0) ? ST_IDLE : ST_GAP;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY: begin
        frame_done_d = 1'b1;
        gap_cnt_d    = '0;
        state_d      = (GAP == 0) ? ST_IDLE : ST_GAP;
      end
`endif
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      data_out_q    <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      data_out_q    <= data_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
`ifdef SEQ_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  seq_run_counter #(.HIT_W(hit_w(WIDTH))) u_run_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_en    (bit_valid_d),
    .bit_in    (data_out_d),
    .hit_count (hit_count)
  );

  assign data_out    = data_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sequence_tx.sv
// Directed testbench for sequence_tx (WIDTH=8, GAP=2).
// Follows SEQ_TX_PARITY_EN when defined for the build.
module tb_sequence_tx;
  import seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;
  logic          data_out;
  logic          bit_valid;
  logic          frame_start;
  logic          frame_done;
  logic [3:0]    hit_count;
  seq_tx_state_t dbg_state;

  int tests_run = 0;
  int failures  = 0;

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
    $fatal(1, "timeout");
  end

  sequence_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .data_out    (data_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .hit_count   (hit_count),
    .dbg_state   (dbg_state)
  );

  // Waits (bounded) at negedges until load_ready is high.
  task automatic wait_ready(input string name);
    int n = 0;
    while (load_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_ready: load_ready got %b want 1 within 50 cycles", name, load_ready);
    end
  endtask

  // Sends one word and checks every frame bit, frame_done, the gap and the idle cycle.
  // hold_valid keeps load_valid high with changing load_data during the frame.
  task automatic run_frame(input logic [7:0] word, input int exp_hits,
                           input bit hold_valid, input string name);
    logic [8:0] fb;
    int         nbits;
    int         run_hits;
    int         det_hits;
    logic       prev_obs;
    fb    = {word, 1'b0};
    nbits = 8;
`ifdef SEQ_TX_PARITY_EN
    fb[0] = ^word;
    nbits = 9;
`endif
    wait_ready(name);
    load_valid = 1'b1;
    load_data  = word;
    @(negedge clk);
    run_hits = 0;
    det_hits = 0;
    prev_obs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (!hold_valid) load_valid = 1'b0;
      load_data = 8'($urandom_range(0, 255));
      if (i > 0 && fb[8-i] && fb[9-i]) run_hits++;
      tests_run++;
      if ({data_out, bit_valid, frame_start, frame_done, load_ready} !==
          {fb[8-i], 1'b1, (i == 0), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s bit%0d {data,valid,start,done,ready}: got %b want %b", name, i,
                 {data_out, bit_valid, frame_start, frame_done, load_ready},
                 {fb[8-i], 1'b1, (i == 0), 1'b0, 1'b0});
      end
      tests_run++;
      if (hit_count !== 4'(run_hits)) begin
        failures++;
        $display("FAIL %s bit%0d hit_count: got %0d want %0d", name, i, hit_count, run_hits);
      end
      if (i > 0 && data_out === 1'b1 && prev_obs === 1'b1) det_hits++;
      prev_obs = data_out;
      @(negedge clk);
    end
    tests_run++;
    if ({data_out, bit_valid, frame_start, frame_done} !== 4'b0001) begin
      failures++;
      $display("FAIL %s frame_done cycle {data,valid,start,done}: got %b want 0001", name,
               {data_out, bit_valid, frame_start, frame_done});
    end
    tests_run++;
    if (hit_count !== 4'(exp_hits)) begin
      failures++;
      $display("FAIL %s final hit_count: got %0d want %0d", name, hit_count, exp_hits);
    end
    tests_run++;
    if (det_hits != exp_hits) begin
      failures++;
      $display("FAIL %s detector hits on stream: got %0d want %0d", name, det_hits, exp_hits);
    end
    for (int g = 1; g < GAP; g++) begin
      @(negedge clk);
      tests_run++;
      if ({data_out, bit_valid, frame_done, load_ready} !== 4'b0000) begin
        failures++;
        $display("FAIL %s gap%0d {data,valid,done,ready}: got %b want 0000", name, g,
                 {data_out, bit_valid, frame_done, load_ready});
      end
    end
    @(negedge clk);
    tests_run++;
    if ({data_out, bit_valid, frame_done, load_ready} !== 4'b0001 || hit_count !== 4'(exp_hits)) begin
      failures++;
      $display("FAIL %s idle {data,valid,done,ready}: got %b want 0001, hit_count got %0d want %0d",
               name, {data_out, bit_valid, frame_done, load_ready}, hit_count, exp_hits);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({data_out, bit_valid, frame_start, frame_done, load_ready, hit_count} !== 9'b0) begin
        failures++;
        $display("FAIL reset cycle%0d outputs: got %b want 000000000", c,
                 {data_out, bit_valid, frame_start, frame_done, load_ready, hit_count});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (load_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset release: load_ready got %b want 1, state got %0d want %0d",
               load_ready, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_basic_b6();
    run_frame(8'hB6, 2, 1'b0, "b6");
  endtask

  task automatic test_patterns();
    run_frame(8'hFF, 7, 1'b0, "ff");
    run_frame(8'h55, 0, 1'b0, "55");
  endtask

  task automatic test_parity();
`ifdef SEQ_TX_PARITY_EN
    run_frame(8'h01, 1, 1'b0, "parity01");
`else
    run_frame(8'h01, 0, 1'b0, "noparity01");
`endif
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA5, 0, 1'b1, "hold_a5");
    run_frame(8'h0F, 3, 1'b0, "next_0f");
  endtask

  task automatic test_reset_mid_frame();
    int exp_h[5] = '{0, 1, 2, 3, 3};
    logic [7:0] w;
    w = 8'hF0;
    wait_ready("midrst");
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({data_out, bit_valid} !== {w[7-i], 1'b1} || hit_count !== 4'(exp_h[i])) begin
        failures++;
        $display("FAIL midrst bit%0d {data,valid}: got %b want %b, hit_count got %0d want %0d",
                 i, {data_out, bit_valid}, {w[7-i], 1'b1}, hit_count, exp_h[i]);
      end
      if (i == 4) rst = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if ({data_out, bit_valid, frame_done, hit_count} !== 7'b0) begin
      failures++;
      $display("FAIL midrst after reset {data,valid,done,hit}: got %b want 0000000",
               {data_out, bit_valid, frame_done, hit_count});
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests_run++;
      if ({data_out, bit_valid, frame_done} !== 3'b000) begin
        failures++;
        $display("FAIL midrst quiet cycle%0d {data,valid,done}: got %b want 000", c,
                 {data_out, bit_valid, frame_done});
      end
    end
    run_frame(8'h3C, 3, 1'b0, "after_rst_3c");
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic_b6();
    test_patterns();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
